// File: rtl/evg_pkg.sv
// ---------------------------------------------------------------------------
// evg_pkg
// Shared constants for the event generator (EVG) transmit path.
//   EVENTCODE_WIDTH_DEFAULT : default event-code width
//   EVCODE_IDLE             : event code meaning "nothing to send"
//   SRC_*                   : fixed source-index assignment of the request
//                             arbiter inputs (index 0 has strict priority)
// ---------------------------------------------------------------------------
package evg_pkg;

    localparam int          EVENTCODE_WIDTH_DEFAULT = 8;
    localparam int unsigned EVCODE_IDLE             = 0;

    localparam int unsigned SRC_SEQUENCER = 0;
    localparam int unsigned SRC_HWTRIG    = 1;
    localparam int unsigned SRC_SOFTWARE  = 2;
    localparam int unsigned SRC_HEARTBEAT = 3;

endpackage : evg_pkg

// File: rtl/evg_rr_arbiter.sv
// ---------------------------------------------------------------------------
// evg_rr_arbiter
// Combinational one-hot round-robin arbiter. The search starts at index `ptr`
// and wraps from N-1 to 0; the first requesting index wins.
// Ports:
//   req   in  N      request vector
//   ptr   in  PTR_W  index searched first
//   grant out N      one-hot grant (all zero when nothing requests)
//   any   out 1      at least one request granted
// ---------------------------------------------------------------------------
module evg_rr_arbiter #(
    parameter  int N     = 4,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             any
);

    int unsigned idx;

    // NOTE: every signal written in this always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!any && idx < N && req[idx]) begin
                grant[idx] = 1'b1;
                any        = 1'b1;
            end
        end
    end

endmodule : evg_rr_arbiter

// File: rtl/evg_event_request_arbiter.sv
// ---------------------------------------------------------------------------
// evg_event_request_arbiter
// Merges AXI-stream event requests into the single event-code slot of the
// EVG transmitter. Source 0 has strict priority; sources 1..N-1 share the
// remaining slots round-robin. Requests carrying the idle code are accepted
// (flushed) at any time without producing output.
// Ports:
//   evgTxClk         in  1                  transmit clock
//   evgTxReset       in  1                  synchronous active-high reset
//   evgTxSlotStrobe  in  1                  this cycle is a fillable slot
//   reqTDATA         in  N*EVENTCODE_WIDTH  per-source event codes
//   reqTVALID        in  N                  per-source request valid
//   reqTREADY        out N                  per-source accept (combinational)
//   evgTxEventCode   out EVENTCODE_WIDTH    granted code, 0 when idle
//   evgTxEventValid  out 1                  evgTxEventCode holds a grant
//   grantIndex       out clog2(N)           source granted on the last slot
//   clearStats       in  1                  clears deferCount
//   deferCount       out DEFER_COUNT_WIDTH  slots that left a request waiting
// ---------------------------------------------------------------------------
module evg_event_request_arbiter
    import evg_pkg::*;
#(
    parameter  int SOURCE_COUNT      = 4,
    parameter  int EVENTCODE_WIDTH   = EVENTCODE_WIDTH_DEFAULT,
    parameter  int DEFER_COUNT_WIDTH = 16,
    localparam int INDEX_WIDTH       = $clog2(SOURCE_COUNT)
) (
    input  logic                                    evgTxClk,
    input  logic                                    evgTxReset,
    input  logic                                    evgTxSlotStrobe,
    input  logic [SOURCE_COUNT*EVENTCODE_WIDTH-1:0] reqTDATA,
    input  logic [SOURCE_COUNT-1:0]                 reqTVALID,
    output logic [SOURCE_COUNT-1:0]                 reqTREADY,
    output logic [EVENTCODE_WIDTH-1:0]              evgTxEventCode,
    output logic                                    evgTxEventValid,
    output logic [INDEX_WIDTH-1:0]                  grantIndex,
    input  logic                                    clearStats,
    output logic [DEFER_COUNT_WIDTH-1:0]            deferCount
);

    localparam logic [EVENTCODE_WIDTH-1:0]   IDLE_CODE = EVENTCODE_WIDTH'(EVCODE_IDLE);
    localparam logic [INDEX_WIDTH-1:0]       PRIO_IDX  = INDEX_WIDTH'(SRC_SEQUENCER);
    localparam logic [INDEX_WIDTH-1:0]       FIRST_RR  = INDEX_WIDTH'(1);
    localparam logic [INDEX_WIDTH-1:0]       LAST_RR   = INDEX_WIDTH'(SOURCE_COUNT - 1);
    localparam logic [DEFER_COUNT_WIDTH-1:0] DEFER_MAX = '1;

    logic [EVENTCODE_WIDTH-1:0] codes [SOURCE_COUNT];
    logic [SOURCE_COUNT-1:0]    eligible;
    logic [SOURCE_COUNT-1:0]    flush;
    logic [SOURCE_COUNT-1:0]    rr_req;
    logic [SOURCE_COUNT-1:0]    rr_grant;
    logic                       rr_any;
    logic [SOURCE_COUNT-1:0]    grant;
    logic                       granted;
    logic [INDEX_WIDTH-1:0]     grant_idx;
    logic [EVENTCODE_WIDTH-1:0] grant_code;
    logic                       defer_event;
    logic [INDEX_WIDTH-1:0]     rr_ptr;

    always_comb begin
        for (int s = 0; s < SOURCE_COUNT; s++) begin
            codes[s]    = reqTDATA[s*EVENTCODE_WIDTH +: EVENTCODE_WIDTH];
            eligible[s] = reqTVALID[s] && (codes[s] != IDLE_CODE);
            flush[s]    = reqTVALID[s] && (codes[s] == IDLE_CODE);
        end
        // The priority source never takes part in the round-robin.
        rr_req           = eligible;
        rr_req[PRIO_IDX] = 1'b0;
    end

    evg_rr_arbiter #(
        .N (SOURCE_COUNT)
    ) u_rr_arbiter (
        .req   (rr_req),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .any   (rr_any)
    );

    always_comb begin
        grant = '0;
        if (evgTxSlotStrobe) begin
            if (eligible[PRIO_IDX]) grant[PRIO_IDX] = 1'b1;
            else                    grant           = rr_grant;
        end
        granted    = evgTxSlotStrobe && (eligible[PRIO_IDX] || rr_any);
        grant_idx  = '0;
        grant_code = IDLE_CODE;
        for (int s = 0; s < SOURCE_COUNT; s++) begin
            if (grant[s]) begin
                grant_idx  = INDEX_WIDTH'(s);
                grant_code = codes[s];
            end
        end
        defer_event = evgTxSlotStrobe && |(eligible & ~grant);
        // No transfer may complete in a reset cycle.
        reqTREADY   = evgTxReset ? '0 : (flush | grant);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge evgTxClk) begin
        if (evgTxReset) begin
            evgTxEventCode  <= IDLE_CODE;
            evgTxEventValid <= 1'b0;
            grantIndex      <= '0;
            deferCount      <= '0;
            rr_ptr          <= FIRST_RR;
        end else begin
            evgTxEventValid <= granted;
            evgTxEventCode  <= granted ? grant_code : IDLE_CODE;
            if (granted) grantIndex <= grant_idx;

            // A priority grant leaves the round-robin position untouched.
            if (granted && grant_idx != PRIO_IDX)
                rr_ptr <= (grant_idx == LAST_RR) ? FIRST_RR : grant_idx + FIRST_RR;

            if (clearStats)
                deferCount <= '0;
            else if (defer_event && deferCount != DEFER_MAX)
                deferCount <= deferCount + 1'b1;
        end
    end

endmodule : evg_event_request_arbiter

// File: tb/tb_evg_event_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_evg_event_request_arbiter
// Table-driven bench for evg_event_request_arbiter (4 sources, 8-bit codes,
// 16-bit deferral counter). Each table row drives one cycle; reqTREADY is
// compared before the edge, registered outputs after it through a queue.
// ---------------------------------------------------------------------------
module tb_evg_event_request_arbiter;

    import evg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        clr;
    logic [31:0] tdata;
    logic [3:0]  tvalid;
    logic [3:0]  tready;
    logic [7:0]  ev_code;
    logic        ev_valid;
    logic [1:0]  gidx;
    logic [15:0] defer;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    evg_event_request_arbiter #(
        .SOURCE_COUNT      (4),
        .EVENTCODE_WIDTH   (8),
        .DEFER_COUNT_WIDTH (16)
    ) dut (
        .evgTxClk        (clk),
        .evgTxReset      (rst),
        .evgTxSlotStrobe (stb),
        .reqTDATA        (tdata),
        .reqTVALID       (tvalid),
        .reqTREADY       (tready),
        .evgTxEventCode  (ev_code),
        .evgTxEventValid (ev_valid),
        .grantIndex      (gidx),
        .clearStats      (clr),
        .deferCount      (defer)
    );

    typedef struct {
        logic        rst;
        logic        stb;
        logic        clr;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [7:0]  exp_code;
        logic        exp_vld;
        logic [1:0]  exp_gidx;
        logic [15:0] exp_defer;
    } vec_t;

    typedef struct {
        logic [7:0]  code;
        logic        vld;
        logic [1:0]  gidx;
        logic [15:0] defer;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic r, input logic s, input logic c,
                                input logic [3:0] v, input logic [31:0] d,
                                input logic [3:0] er, input logic [7:0] ec,
                                input logic ev, input logic [1:0] eg,
                                input logic [15:0] ed);
        vec_t t;
        t.rst = r; t.stb = s; t.clr = c; t.valid = v; t.data = d;
        t.exp_ready = er; t.exp_code = ec; t.exp_vld = ev;
        t.exp_gidx = eg; t.exp_defer = ed;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input string tag, input vec_t v);
        exp_t e;
        rst    = v.rst;
        stb    = v.stb;
        clr    = v.clr;
        tvalid = v.valid;
        tdata  = v.data;
        #1;
        check({tag, " reqTREADY"}, 32'(tready), 32'(v.exp_ready));
        sb.push_back('{code: v.exp_code, vld: v.exp_vld, gidx: v.exp_gidx, defer: v.exp_defer});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, " code"},  32'(ev_code),  32'(e.code));
        check({tag, " valid"}, 32'(ev_valid), 32'(e.vld));
        check({tag, " gidx"},  32'(gidx),     32'(e.gidx));
        check({tag, " defer"}, 32'(defer),    32'(e.defer));
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; clr = 1'b0; tvalid = '0; tdata = '0;

        //          rst  stb  clr  valid    data           ready    code   vld  gidx defer
        // reset state
        vecs.push_back(mk(1, 0, 0, 4'b0000, 32'h00000000, 4'b0000, 8'h00, 0, 2'd0, 16'd0));
        // single request on the software source
        vecs.push_back(mk(0, 1, 0, 4'b0100, 32'h002A0000, 4'b0100, 8'h2A, 1, 2'(SRC_SOFTWARE), 16'd0));
        vecs.push_back(mk(0, 1, 0, 4'b0000, 32'h00000000, 4'b0000, 8'h00, 0, 2'd2, 16'd0));
        // reset with a request pending: no accept, outputs and pointer reset
        vecs.push_back(mk(1, 1, 0, 4'b0100, 32'h002A0000, 4'b0000, 8'h00, 0, 2'd0, 16'd0));
        // three contending round-robin sources
        vecs.push_back(mk(0, 1, 0, 4'b1110, 32'h33221100, 4'b0010, 8'h11, 1, 2'd1, 16'd1));
        vecs.push_back(mk(0, 1, 0, 4'b1110, 32'h33221100, 4'b0100, 8'h22, 1, 2'd2, 16'd2));
        vecs.push_back(mk(0, 1, 0, 4'b1110, 32'h33221100, 4'b1000, 8'h33, 1, 2'd3, 16'd3));
        // clearStats wins over a same-cycle increment
        vecs.push_back(mk(0, 1, 1, 4'b1110, 32'h33221100, 4'b0010, 8'h11, 1, 2'd1, 16'd0));
        vecs.push_back(mk(0, 1, 0, 4'b1100, 32'h33221100, 4'b0100, 8'h22, 1, 2'd2, 16'd1));
        // priority source beats a pending source 3; pointer stays at 3
        vecs.push_back(mk(0, 1, 0, 4'b1001, 32'h3300007E, 4'b0001, 8'h7E, 1, 2'd0, 16'd2));
        vecs.push_back(mk(0, 1, 0, 4'b1010, 32'h33004400, 4'b1000, 8'h33, 1, 2'd3, 16'd3));
        vecs.push_back(mk(0, 1, 0, 4'b0010, 32'h00004400, 4'b0010, 8'h44, 1, 2'd1, 16'd3));
        // idle-code flush, off-slot and on-slot
        vecs.push_back(mk(0, 0, 0, 4'b0010, 32'h00000000, 4'b0010, 8'h00, 0, 2'd1, 16'd3));
        vecs.push_back(mk(0, 1, 0, 4'b0011, 32'h00000000, 4'b0011, 8'h00, 0, 2'd1, 16'd3));
        // sparse slots: accept only on the strobe cycle
        vecs.push_back(mk(0, 0, 0, 4'b0010, 32'h00005500, 4'b0000, 8'h00, 0, 2'd1, 16'd3));
        vecs.push_back(mk(0, 0, 0, 4'b0010, 32'h00005500, 4'b0000, 8'h00, 0, 2'd1, 16'd3));
        vecs.push_back(mk(0, 0, 0, 4'b0010, 32'h00005500, 4'b0000, 8'h00, 0, 2'd1, 16'd3));
        vecs.push_back(mk(0, 1, 0, 4'b0010, 32'h00005500, 4'b0010, 8'h55, 1, 2'd1, 16'd3));
        vecs.push_back(mk(0, 0, 0, 4'b0010, 32'h00005600, 4'b0000, 8'h00, 0, 2'd1, 16'd3));
        vecs.push_back(mk(0, 0, 0, 4'b0010, 32'h00005600, 4'b0000, 8'h00, 0, 2'd1, 16'd3));
        // reset mid-request on a slot cycle
        vecs.push_back(mk(1, 1, 0, 4'b0010, 32'h00005600, 4'b0000, 8'h00, 0, 2'd0, 16'd0));
        // pointer is back at 1: source 1 wins over source 2
        vecs.push_back(mk(0, 1, 0, 4'b0110, 32'h00665600, 4'b0010, 8'h56, 1, 2'd1, 16'd1));
        vecs.push_back(mk(0, 1, 0, 4'b0100, 32'h00660000, 4'b0100, 8'h66, 1, 2'd2, 16'd1));
        // pointer at 3 wraps to 1
        vecs.push_back(mk(0, 1, 0, 4'b0010, 32'h00007700, 4'b0010, 8'h77, 1, 2'd1, 16'd1));
        vecs.push_back(mk(0, 0, 0, 4'b0000, 32'h00000000, 4'b0000, 8'h00, 0, 2'd1, 16'd1));

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("row%0d", i), vecs[i]);

        // Sustained contention between sources 1 and 2 (pointer at 2, count
        // at 1): 65534 more deferring slots bring the count to all-ones.
        rst = 1'b0; stb = 1'b1; clr = 1'b0; tvalid = 4'b0110; tdata = 32'h00221100;
        repeat (65534) @(posedge clk);
        #1;

        step("sat0", mk(0, 1, 0, 4'b0110, 32'h00221100, 4'b0100, 8'h22, 1, 2'd2, 16'hFFFF));
        step("sat1", mk(0, 1, 0, 4'b0110, 32'h00221100, 4'b0010, 8'h11, 1, 2'd1, 16'hFFFF));
        step("sat_clr", mk(0, 1, 1, 4'b0110, 32'h00221100, 4'b0100, 8'h22, 1, 2'd2, 16'h0000));
        step("post_clr", mk(0, 1, 0, 4'b0110, 32'h00221100, 4'b0010, 8'h11, 1, 2'd1, 16'h0001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_evg_event_request_arbiter
